fetch_unit: RTL and testbench

//  Instruction-fetch front end feeding the IF/ID pipeline register of the pipelined RISC-V core.

---
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues pipelined imem requests
// and buffers in-order responses as {pc, ins} pairs for decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        id_stall,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_ins
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [31:0]   fifo_pc  [DEPTH];
   logic [31:0]   fifo_ins [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] pending;
   logic [CW-1:0] discard;
   logic [CW:0]   credit;
   logic [31:0]   target_pc;
   logic          issue;
   logic          push;
   logic          pop;
   logic          unused_bits;

   // Occupied slots plus in-flight requests never exceed DEPTH, so a push always has room.
   assign credit    = {1'b0, count} + {1'b0, pending};
   assign imem_req  = !rst && !redirect && (credit < (CW+1)'(DEPTH));
   assign imem_addr = fetch_pc;
   assign issue     = imem_req && imem_gnt;
   assign target_pc = {redirect_pc[31:2], 2'b00};
   assign unused_bits = ^redirect_pc[1:0];

   assign push = imem_rvalid && (discard == '0) && !redirect;
   assign pop  = if_valid && !id_stall && !redirect;

   assign if_valid = (count != '0);
   assign if_pc    = if_valid ? fifo_pc[rd_ptr]  : '0;
   assign if_ins   = if_valid ? fifo_ins[rd_ptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         pending  <= '0;
         discard  <= '0;
      end else begin
         pending <= pending + CW'(issue) - CW'(imem_rvalid);
         if (redirect) begin
            fetch_pc <= target_pc;
            resp_pc  <= target_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            // Every response still outstanding after this edge belongs to the old path.
            discard  <= pending - CW'(imem_rvalid);
         end else begin
            if (issue)
               fetch_pc <= fetch_pc + 32'd4;
            if (imem_rvalid && (discard != '0))
               discard <= discard - CW'(1);
            if (push) begin
               resp_pc <= resp_pc + 32'd4;
               wr_ptr  <= wr_ptr + AW'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]  <= resp_pc;
         fifo_ins[wr_ptr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory with random latency and a
// queue-based reference of in-flight fetches and presented instructions.
module tb_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_stall = 1'b0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_ins;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(gnt),
      .imem_rvalid(rvalid), .imem_rdata(rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .id_stall(id_stall),
      .if_valid(if_valid), .if_pc(if_pc), .if_ins(if_ins)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic        stale;
   } inf_t;

   int n_chk  = 0;
   int n_pass = 0;

   // memory side: addresses the DUT actually issued, answered in order
   logic [31:0] mq [$];
   // reference: fetch PC, in-flight fetches and instructions awaiting decode
   logic [31:0] fpc;
   inf_t        inf [$];
   logic [31:0] fq_pc [$];
   logic [31:0] fq_ins [$];

   function automatic logic [31:0] ins_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      fpc = RESET_PC;
      inf.delete();
      fq_pc.delete();
      fq_ins.delete();
   endtask

   // one cycle; entered and left at a falling edge
   task automatic step(input int pg, input int ps, input int pr, input int prv);
      logic m_req;
      logic dut_issue;
      logic [31:0] dut_addr;
      inf_t e;
      int sel;
      gnt      = ($urandom % 100) < pg;
      id_stall = ($urandom % 100) < ps;
      redirect = ($urandom % 100) < pr;
      sel = $urandom % 4;
      case (sel)
         0: redirect_pc = 32'h0000_0100;
         1: redirect_pc = 32'h0000_0203;
         2: redirect_pc = 32'hFFFF_FFF8 | ($urandom % 4);
         default: redirect_pc = $urandom;
      endcase
      rvalid = (mq.size() > 0) && (($urandom % 100) < prv);
      rdata  = rvalid ? ins_of(mq[0]) : $urandom;
      #1;
      m_req = !redirect && ((fq_pc.size() + inf.size()) < DEPTH);
      chk("imem_req", imem_req, m_req);
      chk("imem_addr", imem_addr, fpc);
      chk("if_valid", if_valid, fq_pc.size() > 0);
      chk("if_pc", if_pc, fq_pc.size() > 0 ? fq_pc[0] : 32'h0);
      chk("if_ins", if_ins, fq_ins.size() > 0 ? fq_ins[0] : 32'h0);
      dut_issue = imem_req && gnt;
      dut_addr  = imem_addr;
      @(posedge clk);
      if (rvalid) void'(mq.pop_front());
      if (dut_issue) mq.push_back(dut_addr);
      if (redirect) begin
         foreach (inf[i]) inf[i].stale = 1'b1;
         if (rvalid && inf.size() > 0) void'(inf.pop_front());
         fq_pc.delete();
         fq_ins.delete();
         fpc = {redirect_pc[31:2], 2'b00};
      end else begin
         if (fq_pc.size() > 0 && !id_stall) begin
            void'(fq_pc.pop_front());
            void'(fq_ins.pop_front());
         end
         if (rvalid && inf.size() > 0) begin
            e = inf.pop_front();
            if (!e.stale) begin
               fq_pc.push_back(e.a);
               fq_ins.push_back(ins_of(e.a));
            end
         end
         if (m_req && gnt) begin
            inf.push_back('{a: fpc, stale: 1'b0});
            fpc = fpc + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   task automatic run(input int n, input int pg, input int ps, input int pr, input int prv);
      for (int i = 0; i < n; i++) step(pg, ps, pr, prv);
   endtask

   // asserted at a falling edge; stale responses arrive while held
   task automatic do_reset();
      rst = 1'b1;
      gnt = 1'b1;
      redirect = 1'b0;
      id_stall = 1'b0;
      rvalid = 1'b0;
      #1;
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", if_valid, 1'b0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_ins", if_ins, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rvalid = 1'b1;
         rdata  = $urandom;
         #1;
         chk("rst_hold_valid", if_valid, 1'b0);
         chk("rst_hold_req", imem_req, 1'b0);
      end
      @(negedge clk);
      rvalid = 1'b0;
      mq.delete();
      model_reset();
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();
      run(40, 100, 0, 0, 100);     // streaming, one instruction per cycle
      run(10, 100, 100, 0, 100);   // decode stalled: issues stop at DEPTH
      run(20, 100, 0, 0, 100);
      run(3, 0, 0, 0, 100);        // grant withheld
      run(20, 100, 0, 0, 100);
      run(400, 70, 30, 8, 60);
      run(6, 100, 100, 0, 0);      // build up in-flight requests
      do_reset();
      run(30, 100, 0, 0, 100);
      run(300, 60, 40, 20, 50);    // frequent, often back-to-back redirects
      run(300, 80, 20, 5, 80);
      run(5, 100, 100, 0, 0);
      do_reset();
      run(200, 70, 30, 10, 60);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
